data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 35 +++
 rtl/data_mem_responder_mem_lane_align.sv | 65 ++++++
 rtl/data_mem_responder.sv | 119 +++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data memory responder: RV32I access
// size encodings, FSM state type and the default response latency.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Encoding and alignment legality only; range is checked by the owner of the array.
    function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational byte-lane logic: store byte-enables and merged write word,
// and load byte/half extraction with sign or zero extension.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wmerged,
    output logic [31:0] rdata
);

    logic [31:0] wlanes;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be     = '0;
        wlanes = '0;
        case (funct3[1:0])
            2'b00: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            2'b10: begin
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: begin
                be     = '0;
                wlanes = '0;
            end
        endcase
    end

    always_comb begin
        wmerged = rword;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                wmerged[8*i +: 8] = wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        byte_v = rword[8*addr_lo +: 8];
        half_v = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata  = '0;
        case (funct3)
            F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
            F3_H:    rdata = {{16{half_v[15]}}, half_v};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'd0, byte_v};
            F3_HU:   rdata = {16'd0, half_v};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed latency, backed by a
// single-port byte-writable word array.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;
    logic [AW-1:0] idx;

    logic        accept;
    logic        fire;
    logic        done;
    logic        access_err;
    logic        mem_we;
    logic [3:0]  be;
    logic [31:0] wmerged;
    logic [31:0] ld_data;

    assign accept     = req_valid && (state == ST_IDLE);
    assign fire       = (state == ST_WAIT) && (cnt == '0);
    assign done       = (state == ST_RESP) && rsp_ready;
    assign access_err = access_illegal(we_q, f3_q, addr_q[1:0]) || (addr_q[31:2] >= DEPTH_LIM);
    assign mem_we     = fire && we_q && !access_err && (be != '0);

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // The single port follows the incoming request while idle so the word is
    // already read out by the time the latency counter expires, even at LATENCY=1.
    assign idx = (state == ST_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];

    mem_lane_align u_lane (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .rword   (rd_word),
        .be      (be),
        .wmerged (wmerged),
        .rdata   (ld_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_WAIT;
            ST_WAIT: if (fire)   state_n = ST_RESP;
            ST_RESP: if (done)   state_n = ST_IDLE;
            default:             state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt     <= LAT_M1;
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                rsp_err   <= access_err;
                rsp_rdata <= (we_q || access_err) ? '0 : ld_data;
            end else if (done) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wmerged;
        end
        rd_word <= mem[idx];
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array
// reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] mem_b [4*DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1;
        if (size_of(f3) == 2 && a[0]) return 1;
        if (size_of(f3) == 4 && a[1:0] != 2'b00) return 1;
        if ((a / 4) >= DEPTH) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        longint unsigned v;
        int sz;
        sz = size_of(f3);
        v = 0;
        for (int i = 0; i < sz; i++) v += longint'(mem_b[int'(a) + i]) << (8 * i);
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v + 64'hFFFF_FFFF - ((64'd1 << (8 * sz)) - 1);
        return v[31:0];
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        w = wd;
        for (int i = 0; i < size_of(f3); i++) mem_b[int'(a) + i] = w[8*i +: 8];
    endtask

    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output bit e, output int lat,
                       output bit held_ok, output bit rdy_after);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; e = rsp_err; held_ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!(rsp_valid === 1'b1 && rsp_rdata === rd && rsp_err === e && req_ready === 1'b0))
                held_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rdy_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
        if (we && !m_err(we, f3, addr)) m_store(f3, addr, wd);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_miss++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [31:0] rd; bit e, h, r; int lat; logic [31:0] wd;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            txn(1'b1, 3'b010, 32'(4 * w), wd, 0, rd, e, lat, h, r);
            n_vec++; if (e !== 1'b0 || rd !== 32'h0) begin n_miss++; $display("FAIL init_sw: got err=%b rd=%h want err=0 rd=0", e, rd); end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd; bit e, h, r; int lat;
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, e, lat, h, r);
        n_vec++; if (lat != LAT) begin n_miss++; $display("FAIL sw_latency: got %0d want %0d", lat, LAT); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_miss++; $display("FAIL lw_deadbeef: got %h err=%b want deadbeef err=0", rd, e); end
        n_vec++; if (lat != LAT) begin n_miss++; $display("FAIL lw_latency: got %0d want %0d", lat, LAT); end

        txn(1'b1, 3'b010, 32'h10, 32'h0, 0, rd, e, lat, h, r);
        txn(1'b1, 3'b000, 32'h13, 32'h80, 0, rd, e, lat, h, r);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'h80000000) begin n_miss++; $display("FAIL sb_lw: got %h want 80000000", rd); end
        txn(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'hFFFFFF80) begin n_miss++; $display("FAIL lb_sign: got %h want ffffff80", rd); end
        txn(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'h00000080) begin n_miss++; $display("FAIL lbu_zero: got %h want 00000080", rd); end

        txn(1'b1, 3'b001, 32'h22, 32'h8001, 0, rd, e, lat, h, r);
        txn(1'b0, 3'b001, 32'h22, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'hFFFF8001) begin n_miss++; $display("FAIL lh_sign: got %h want ffff8001", rd); end
        txn(1'b0, 3'b101, 32'h22, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'h00008001) begin n_miss++; $display("FAIL lhu_zero: got %h want 00008001", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; bit e, h, r; int lat; logic [31:0] w0, w1;
        w0 = m_load(3'b010, 32'h0);
        w1 = m_load(3'b010, 32'h4);
        txn(1'b0, 3'b010, 32'h2, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_miss++; $display("FAIL lw_misalign: got err=%b rd=%h want err=1 rd=0", e, rd); end
        txn(1'b1, 3'b001, 32'h5, 32'hFFFF, 0, rd, e, lat, h, r);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_miss++; $display("FAIL sh_misalign: got err=%b rd=%h want err=1 rd=0", e, rd); end
        txn(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_miss++; $display("FAIL lw_range: got err=%b rd=%h want err=1 rd=0", e, rd); end
        txn(1'b0, 3'b010, 32'h0, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== w0 || e !== 1'b0) begin n_miss++; $display("FAIL word0_intact: got %h want %h", rd, w0); end
        txn(1'b0, 3'b010, 32'h4, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== w1 || e !== 1'b0) begin n_miss++; $display("FAIL word1_intact: got %h want %h", rd, w1); end
    endtask

    task automatic test_hold();
        logic [31:0] rd; bit e, h, r; int lat; logic [31:0] exp;
        exp = m_load(3'b010, 32'h10);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 3, rd, e, lat, h, r);
        n_vec++; if (rd !== exp) begin n_miss++; $display("FAIL hold_data: got %h want %h", rd, exp); end
        n_vec++; if (h !== 1'b1) begin n_miss++; $display("FAIL hold_stable: got %b want 1", h); end
        n_vec++; if (r !== 1'b1) begin n_miss++; $display("FAIL hold_return_idle: got %b want 1", r); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wd; bit e, h, r, we, exp_e; int lat, hold; logic [2:0] f3;
        for (int k = 0; k < 300; k++) begin
            we   = $urandom_range(0, 1);
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            exp_e  = m_err(we, f3, addr);
            exp_rd = (we || exp_e) ? 32'h0 : m_load(f3, addr);
            txn(we, f3, addr, wd, hold, rd, e, lat, h, r);
            n_vec++;
            if (rd !== exp_rd || e !== exp_e || lat != LAT || h !== 1'b1 || r !== 1'b1) begin
                n_miss++;
                $display("FAIL rand[%0d] we=%b f3=%0d a=%h: got rd=%h err=%b lat=%0d hold=%b idle=%b want rd=%h err=%b lat=%0d",
                         k, we, f3, addr, rd, e, lat, h, r, exp_rd, exp_e, LAT);
            end
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; bit e, h, r, seen; int lat;
        txn(1'b1, 3'b010, 32'h40, 32'h0, 0, rd, e, lat, h, r);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL rst_wait_no_rsp: got %b want 0", seen); end
        txn(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, e, lat, h, r);
        n_vec++; if (rd !== 32'h0) begin n_miss++; $display("FAIL rst_wait_no_write: got %h want 00000000", rd); end
    endtask

    task automatic test_reset_resp();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL rst_resp_reach: got %b want 1", rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_miss++; $display("FAIL rst_resp_drop: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_resp_gone: got %b want 0", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_errors();
        test_hold();
        test_random();
        test_reset_wait();
        test_reset_resp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
